// File: rtl/dbf_ch_dynfocus_pkg.sv
// Shared defaults and types for the dynamic-focus receive beamforming channel.
// ZONES and BUF_DEPTH describe the default geometry; instances derive their own from parameters.
package dbf_ch_dynfocus_pkg;

  localparam int DEF_INPUT_WD = 14;
  localparam int DEF_APO_WD   = 16;
  localparam int DEF_APO_FRAC = 15;
  localparam int DEF_OUT_WD   = 32;
  localparam int DEF_BUF_AW   = 7;
  localparam int DEF_LUT_AW   = 6;
  localparam int DEF_ZONE_LEN = 64;

  localparam int ZONES     = 1 << DEF_LUT_AW;
  localparam int BUF_DEPTH = 1 << DEF_BUF_AW;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dbf_delay_ram.sv
// Simple dual-port RAM: one write port, one registered read port with write-first bypass.
// The memory array itself is not reset; only the read register is.
module dbf_delay_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read during a write returns the word being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/dbf_ch_dynfocus.sv
// Receive beamforming channel: circular delay line with per-zone coarse delay
// (dynamic focusing), then signed apodisation with half-up rounding and saturation.
module dbf_ch_dynfocus
  import dbf_ch_dynfocus_pkg::*;
#(
  parameter int INPUT_WD = DEF_INPUT_WD,
  parameter int APO_WD   = DEF_APO_WD,
  parameter int APO_FRAC = DEF_APO_FRAC,
  parameter int OUT_WD   = DEF_OUT_WD,
  parameter int BUF_AW   = DEF_BUF_AW,
  parameter int LUT_AW   = DEF_LUT_AW,
  parameter int ZONE_LEN = DEF_ZONE_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                start,
  input  logic [INPUT_WD-1:0] ch_in,
  input  logic [APO_WD-1:0]   apo_din,
  input  logic [LUT_AW-1:0]   lut_addr,
  input  logic [BUF_AW-1:0]   lut_wdata,
  input  logic                lut_we,
  output logic [OUT_WD-1:0]   dout,
  output logic                dout_valid,
  output logic [INPUT_WD-1:0] cd_dout,
  output logic                lut_wr_err
);

  localparam int PW   = INPUT_WD + APO_WD;
  localparam int EW   = (((PW + 1) > OUT_WD) ? (PW + 1) : OUT_WD) + 1;
  localparam int ZC_W = $clog2(ZONE_LEN);

  localparam logic [ZC_W-1:0]        ZC_LAST   = ZC_W'(ZONE_LEN - 1);
  localparam logic [LUT_AW-1:0]      ZONE_LAST = '1;
  localparam logic [BUF_AW-1:0]      FILL_MAX  = '1;
  localparam logic signed [EW-1:0]   RND_HALF  = {{(EW-1){1'b0}}, 1'b1} << (APO_FRAC - 1);
  localparam logic signed [EW-1:0]   SAT_MAX   = {{(EW-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
  localparam logic signed [EW-1:0]   SAT_MIN   = ~SAT_MAX;

  function automatic logic [OUT_WD-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic [OUT_WD-1:0]    res;
    ext = {{(EW-PW){p[PW-1]}}, p};
    rnd = (ext + RND_HALF) >>> APO_FRAC;
    res = rnd[OUT_WD-1:0];
    if (rnd > SAT_MAX)      res = {1'b0, {(OUT_WD-1){1'b1}}};
    else if (rnd < SAT_MIN) res = {1'b1, {(OUT_WD-1){1'b0}}};
    return res;
  endfunction

  state_t              state, state_nxt;
  logic                accept, enter_run;
  logic [BUF_AW-1:0]   wr_ptr, fill_cnt, cur_delay, rd_addr;
  logic [ZC_W-1:0]     zone_cnt;
  logic [LUT_AW-1:0]   zone_idx, lut_raddr;
  logic [INPUT_WD-1:0] dl_rdata, dly;
  logic [APO_WD-1:0]   apo1;
  logic                v1, v2, blank1;
  logic signed [PW-1:0] prod2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (!start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept    = (state == ST_RUN) & start & ~tx_en;
  assign enter_run = (state == ST_IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      zone_cnt <= '0;
      zone_idx <= '0;
    end else if (enter_run) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      zone_cnt <= '0;
      zone_idx <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      if (zone_cnt == ZC_LAST) begin
        zone_cnt <= '0;
        if (zone_idx != ZONE_LAST) zone_idx <= zone_idx + 1'b1;
      end else begin
        zone_cnt <= zone_cnt + 1'b1;
      end
    end
  end

  // Zone 0 is fetched on the IDLE->RUN edge so the first accept already sees its delay.
  assign lut_raddr = enter_run ? '0 : zone_idx;

  dbf_delay_ram #(.AW(LUT_AW), .DW(BUF_AW)) u_zone_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we & (state == ST_IDLE)),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .re    (1'b1),
    .raddr (lut_raddr),
    .rdata (cur_delay)
  );

  assign rd_addr = wr_ptr - cur_delay;

  dbf_delay_ram #(.AW(BUF_AW), .DW(INPUT_WD)) u_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (ch_in),
    .re    (accept),
    .raddr (rd_addr),
    .rdata (dl_rdata)
  );

  assign dly = blank1 ? '0 : dl_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      blank1     <= 1'b0;
      apo1       <= '0;
      v2         <= 1'b0;
      prod2      <= '0;
      cd_dout    <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      lut_wr_err <= 1'b0;
    end else begin
      v1         <= accept;
      v2         <= v1;
      dout_valid <= v2;
      lut_wr_err <= lut_we & (state == ST_RUN);
      if (accept) begin
        blank1 <= (fill_cnt < cur_delay);
        apo1   <= apo_din;
      end
      if (v1) begin
        cd_dout <= dly;
        prod2   <= $signed(dly) * $signed(apo1);
      end
      if (v2) dout <= round_sat(prod2);
    end
  end

endmodule
